serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that sequences one shared full-adder slice (two half-adder stages plus OR) over WIDTH-bit operands, LSB first, one bit per clock.
- Trades WIDTH cycles of latency for a single adder slice; sits between a requesting unit and the arithmetic datapath.
- Provides a start/busy/done handshake and holds the result until the next accepted operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CW, 5, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is idle or done.
- A  input  WIDTH  operand A; latched on the accepting edge.
- B  input  WIDTH  operand B; latched on the accepting edge.
- cin  input  1  carry-in; latched on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum and carry become valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- carry  output  1  final carry-out; held with sum.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0; done=0; sum=0; carry=0.
  - Internal A/B shift registers, carry flip-flop and bit counter cleared.
  - Asserting rst mid-operation aborts it; no done pulse is produced for the aborted operation.
- State IDLE:
  - start=1 at an edge latches A, B and cin (cin loads the carry flip-flop), sets count=0 and moves to RUN.
  - start=0 stays in IDLE.
- State RUN (busy=1):
  - Each edge:
    - Computes s=a0^b0^c and c'=(a0&b0)|((a0^b0)&c) through the half-adder pair.
    - Shifts s into the MSB of the sum register (right shift) and shifts both operand registers right.
    - Loads the carry flip-flop with c' and increments count.
  - At the edge where count==WIDTH-1, the last bit is processed, carry takes c' and the state moves to DONE.
  - start is ignored in RUN; A, B and cin are don't-care.
- State DONE (done=1, busy=0, single cycle):
  - start=1 is accepted exactly as in IDLE, so back-to-back operations run with a 1-cycle gap.
  - Otherwise the state moves to IDLE.
- Latency:
  - Accepting edge at edge k; done is high during the cycle after edge k+WIDTH.
  - busy is high for exactly WIDTH cycles.
- sum and carry are updated only by RUN edges. They are undefined/partial while busy=1 and stable otherwise.
- Arithmetic: {carry,sum} = A + B + cin, modulo 2^(WIDTH+1); no signed interpretation.
- busy and done are mutually exclusive and are never both high.
- WIDTH=1: RUN lasts one cycle; done follows on the next cycle.

Test Plan:
- Reset and idle: assert rst mid-RUN (A=8'hFF, B=8'h01, after 3 RUN cycles) -> busy, done, sum and carry go to 0 immediately; no done pulse afterwards; state is IDLE.
- Basic add: A=8'h35, B=8'h1A, cin=0, start pulse -> busy for 8 cycles, then done pulse; sum=8'h4F, carry=0.
- Carry chain: A=8'hFF, B=8'h00, cin=1 -> sum=8'h00, carry=1; done exactly 8 edges after the accepting edge.
- Start while busy: start re-asserted with A=8'h01, B=8'h01 during RUN of A=8'h80, B=8'h80 -> second request ignored; result sum=8'h00, carry=1; only one done pulse.
- Back-to-back: start held high through DONE with A=8'h0F, B=8'h01 -> accepted on the DONE edge; first result held during its done cycle, then the second run gives sum=8'h10, carry=0.
- Random: 1000 random A, B, cin at WIDTH=8, plus a sweep at WIDTH=1 -> {carry,sum} matches the reference model every time; busy/done timing as specified.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders plus OR)
// walks WIDTH-bit operands LSB first and holds {carry,sum} until the next start.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Handshake: start is sampled only in IDLE or DONE; busy covers exactly the
  // WIDTH bit-processing cycles; done is a one-cycle pulse, never with busy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             c_reg;
  logic [CW-1:0]    count;
  logic             accept;
  logic             last;

  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             c_next;
  logic [WIDTH-1:0] s_msb;

  assign ha1_s  = a_reg[0] ^ b_reg[0];
  assign ha1_c  = a_reg[0] & b_reg[0];
  assign ha2_s  = ha1_s ^ c_reg;
  assign ha2_c  = ha1_s & c_reg;
  assign c_next = ha1_c | ha2_c;
  assign last   = (count == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    s_msb            = '0;
    s_msb[WIDTH-1]   = ha2_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= 1'b0;
      count <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      a_reg <= A;
      b_reg <= B;
      c_reg <= cin;
      count <= '0;
    end else if (state == RUN) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      c_reg <= c_next;
      count <= count + 1'b1;
      sum   <= (sum >> 1) | s_msb;
      carry <= c_next;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=1: scoreboard of A+B+cin
// pushed on each accepting edge and popped on every done pulse.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, carry1;
  logic [0:0] a1, b1, sum1;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  int n_checks;
  int n_pass;

  serial_add_ctrl #(.WIDTH(8), .CW(5)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_add_ctrl #(.WIDTH(1), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result monitors: every done pulse must match the oldest pending request.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy8 && done8) check("busy_done_excl8", 32'd1, 32'd0);
      if (busy1 && done1) check("busy_done_excl1", 32'd1, 32'd0);
      if (done8) begin
        if (exp_q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
        else check("result8", 32'({carry8, sum8}), 32'(exp_q8.pop_front()));
      end
      if (done1) begin
        if (exp_q1.size() == 0) check("spurious_done1", 32'd1, 32'd0);
        else check("result1", 32'({carry1, sum1}), 32'(exp_q1.pop_front()));
      end
    end
  end

  // mode 0: plain; mode 1: re-request during RUN; mode 2: hold start into DONE.
  task automatic wait_done(input int which, input int mode);
    int w;
    int nb;
    int lat;
    logic bs;
    logic ds;
    w   = (which == 0) ? 8 : 1;
    nb  = 0;
    lat = -1;
    for (int j = 1; j <= 4 * w + 12; j++) begin
      @(negedge clk);
      bs = (which == 0) ? busy8 : busy1;
      ds = (which == 0) ? done8 : done1;
      if (ds) begin
        lat = j - 1;
        break;
      end
      if (bs) nb++;
      if (mode == 1 && j == 2) begin
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      end
      if (mode == 1 && j == 4) start8 = 1'b0;
      if (mode == 2 && j == w) begin
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      end
    end
    if (lat < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("busy_len", 32'(nb), 32'(w));
      check("done_latency", 32'(lat), 32'(w));
    end
  endtask

  task automatic op(input int which, input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input int mode);
    @(negedge clk);
    if (which == 0) begin
      a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    end else begin
      a1 = a[0]; b1 = b[0]; cin1 = ci; start1 = 1'b1;
    end
    @(posedge clk);
    if (which == 0) exp_q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, ci});
    else exp_q1.push_back({1'b0, a[0]} + {1'b0, b[0]} + {1'b0, ci});
    #1;
    start8 = 1'b0;
    start1 = 1'b0;
    wait_done(which, mode);
    if (mode == 2) begin
      @(posedge clk);
      exp_q8.push_back(9'h010);
      #1 start8 = 1'b0;
      wait_done(0, 0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int n;
    n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      if (done8 || done1) n++;
    end
    check(tag, 32'(n), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum", 32'(sum8), 32'd0);
    check("reset_carry", 32'(carry8), 32'd0);
    check("reset_w1", 32'({busy1, done1, sum1, carry1}), 32'd0);
    rst = 1'b0;

    op(0, 8'h35, 8'h1A, 1'b0, 0);
    op(0, 8'hFF, 8'h00, 1'b1, 0);
    op(0, 8'h80, 8'h80, 1'b0, 1);
    expect_quiet("no_extra_done", 12);
    op(0, 8'h35, 8'h1A, 1'b0, 2);

    // Abort mid-RUN: outputs clear at once and no done follows.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_carry", 32'(carry8), 32'd0);
    check("abort_state", 32'(dut8.state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("no_done_after_abort", 15);

    for (int i = 0; i < 1000; i++) begin
      op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), 0);
    end

    for (int i = 0; i < 8; i++) begin
      op(1, 8'(i & 1), 8'((i >> 1) & 1), 1'((i >> 2) & 1), 0);
    end
    for (int i = 0; i < 40; i++) begin
      op(1, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty8", 32'(exp_q8.size()), 32'd0);
    check("queue_empty1", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
